// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ==========================================================================
// pipelined_barrel_shifter: log2-staged rotate/shift unit with valid/ready
// Revision: 1.0 - initial parametrised pipelined release
// ==========================================================================
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam logic [2:0] MODE_ROR = 3'b000;
  localparam logic [2:0] MODE_ROL = 3'b001;
  localparam logic [2:0] MODE_SRL = 3'b010;
  localparam logic [2:0] MODE_SLL = 3'b011;
  localparam logic [2:0] MODE_SRA = 3'b100;
  // Stage k keeps only the amount bits still to be consumed: AW-1-k of them.
  localparam int REM_W = AW * (AW - 1) / 2;

  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  logic [WIDTH-1:0] ent_data;
  logic [AW-1:0]    ent_amt;
  logic             ent_rot, ent_left, ent_fill, ent_err;

  logic [AW-1:0]    v_q, err_q, valid_d, err_d;
  logic [WIDTH-1:0] data_q [AW];
  logic [WIDTH-1:0] data_d [AW];
  logic [AW-2:0]    rot_q, left_q, fill_q, rot_d, left_d, fill_d;
  logic [REM_W-1:0] rem_q, rem_d, rem_en;
  logic [AW:0]      stage_ready;

  // Left modes run as right operations on the bit-reversed word.
  always_comb begin
    ent_rot  = 1'b0;
    ent_left = 1'b0;
    ent_fill = 1'b0;
    ent_err  = 1'b0;
    ent_amt  = in_amt;
    case (in_mode)
      MODE_ROR: ent_rot = 1'b1;
      MODE_ROL: begin
        ent_rot  = 1'b1;
        ent_left = 1'b1;
      end
      MODE_SRL: ent_rot = 1'b0;
      MODE_SLL: ent_left = 1'b1;
      MODE_SRA: ent_fill = in_data[WIDTH-1];
      default: begin
        ent_err = 1'b1;
        ent_amt = '0;
      end
    endcase
    ent_data = ent_left ? bit_reverse(in_data) : in_data;
  end

  always_comb begin
    stage_ready     = '0;
    stage_ready[AW] = out_ready;
    for (int k = AW - 1; k >= 0; k--) stage_ready[k] = !v_q[k] || stage_ready[k+1];
  end

  for (genvar k = 0; k < AW; k++) begin : g_stage
    localparam int SH   = 1 << k;
    localparam int OFF  = k * (AW - 1) - (k * (k - 1)) / 2;
    localparam int POFF = (k - 1) * (AW - 1) - ((k - 1) * (k - 2)) / 2;

    logic [WIDTH-1:0] src, moved, shifted;
    logic [AW-1-k:0]  src_rem;
    logic             src_valid, src_rot, src_left, src_fill, src_err;

    if (k == 0) begin : g_head
      assign src       = ent_data;
      assign src_rem   = ent_amt;
      assign src_valid = in_valid;
      assign src_rot   = ent_rot;
      assign src_left  = ent_left;
      assign src_fill  = ent_fill;
      assign src_err   = ent_err;
    end else begin : g_tail
      assign src       = data_q[k-1];
      assign src_rem   = rem_q[POFF +: AW-k];
      assign src_valid = v_q[k-1];
      assign src_rot   = rot_q[k-1];
      assign src_left  = left_q[k-1];
      assign src_fill  = fill_q[k-1];
      assign src_err   = err_q[k-1];
    end

    assign moved   = src_rot ? {src[SH-1:0], src[WIDTH-1:SH]}
                             : {{SH{src_fill}}, src[WIDTH-1:SH]};
    assign shifted = src_rem[0] ? moved : src;
    assign valid_d[k] = src_valid;
    assign err_d[k]   = src_err;

    if (k < AW - 1) begin : g_body
      assign data_d[k] = shifted;
      assign rot_d[k]  = src_rot;
      assign left_d[k] = src_left;
      assign fill_d[k] = src_fill;
      assign rem_d[OFF +: AW-1-k]  = src_rem[AW-1-k:1];
      assign rem_en[OFF +: AW-1-k] = {(AW-1-k){stage_ready[k]}};
    end else begin : g_last
      // Undo the entry reversal so the output register holds the final word.
      assign data_d[k] = src_left ? bit_reverse(shifted) : shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      err_q  <= '0;
      rot_q  <= '0;
      left_q <= '0;
      fill_q <= '0;
      rem_q  <= '0;
      for (int k = 0; k < AW; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < AW; k++) begin
        if (stage_ready[k]) begin
          v_q[k]    <= valid_d[k];
          err_q[k]  <= err_d[k];
          data_q[k] <= data_d[k];
        end
      end
      for (int k = 0; k < AW - 1; k++) begin
        if (stage_ready[k]) begin
          rot_q[k]  <= rot_d[k];
          left_q[k] <= left_d[k];
          fill_q[k] <= fill_d[k];
        end
      end
      for (int b = 0; b < REM_W; b++) begin
        if (rem_en[b]) rem_q[b] <= rem_d[b];
      end
    end
  end

  assign in_ready  = stage_ready[0];
  assign out_valid = v_q[AW-1];
  assign out_data  = data_q[AW-1];
  assign out_err   = err_q[AW-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// Bench for pipelined_barrel_shifter: spec-level model and scoreboard plus
// directed literal checks on an 8-bit and a 32-bit instance.
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, out_err;
  logic [7:0] in_data, out_data;
  logic [2:0] in_amt, in_mode;

  logic        v32, rdy32, ov32, ordy32, oerr32;
  logic [31:0] d32, od32;
  logic [4:0]  a32;
  logic [2:0]  m32;

  pipelined_barrel_shifter #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  pipelined_barrel_shifter #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(v32), .in_ready(rdy32), .in_data(d32),
    .in_amt(a32), .in_mode(m32),
    .out_valid(ov32), .out_ready(ordy32),
    .out_data(od32), .out_err(oerr32)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns {err, data} straight from the mode definitions.
  function automatic logic [8:0] model(input logic [7:0] d, input int n, input logic [2:0] m);
    logic [7:0] r;
    r = d;
    case (m)
      3'd0: for (int i = 0; i < 8; i++) r[i] = d[(i + n) % 8];
      3'd1: for (int i = 0; i < 8; i++) r[i] = d[(i - n + 8) % 8];
      3'd2: for (int i = 0; i < 8; i++) r[i] = (i + n < 8) ? d[i + n] : 1'b0;
      3'd3: for (int i = 0; i < 8; i++) r[i] = (i >= n) ? d[i - n] : 1'b0;
      3'd4: for (int i = 0; i < 8; i++) r[i] = (i + n < 8) ? d[i + n] : d[7];
      default: return {1'b1, d};
    endcase
    return {1'b0, r};
  endfunction

  logic [8:0] expq[$];
  logic [8:0] exp_word;
  int         n_in, n_out;
  logic       hold_v;
  logic [8:0] hold_val;

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      n_in   = 0;
      n_out  = 0;
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {23'd0, out_err, out_data}, {23'd0, hold_val});
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got 0x%0h with no word pending", {out_err, out_data});
        end else begin
          exp_word = expq.pop_front();
          check("model", {23'd0, out_err, out_data}, {23'd0, exp_word});
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(in_data, int'(in_amt), in_mode));
        n_in++;
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {out_err, out_data};
    end
  end

  task automatic send_and_expect(input logic [7:0] d, input logic [2:0] a, input logic [2:0] m,
                                 input logic [8:0] exp, input string name);
    int t;
    bit got;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
    t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    t = 0;
    while (!got && t < 20) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      t++;
    end
    check({name, "_seen"}, {31'd0, got}, 32'd1);
    check(name, {23'd0, out_err, out_data}, {23'd0, exp});
  endtask

  logic [7:0] b1_exp [5];
  logic [7:0] bp_d [5];
  logic [2:0] bp_a [5];
  logic [2:0] bp_m [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx, cnt, t;
    bit  acc;
    b1_exp = '{8'h36, 8'h8D, 8'h16, 8'h88, 8'hF6};
    bp_d   = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    bp_a   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    bp_m   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b1;
    v32 = 1'b0; d32 = '0; a32 = '0; m32 = '0; ordy32 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {24'd0, out_data}, 32'd0);
    check("reset_out_err", {31'd0, out_err}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid32", {31'd0, ov32}, 32'd0);
    check("reset_out_data32", od32, 32'd0);

    // 0xB1 by 3 in the five modes, back to back; exact latency of 3 stages.
    fork
      begin
        for (int j = 0; j < 5; j++) begin
          @(posedge clk); #1;
          in_valid = 1'b1; in_data = 8'hB1; in_amt = 3'd3; in_mode = 3'(j);
        end
        @(posedge clk); #1 in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk) check("b1_not_early", {31'd0, out_valid}, 32'd0);
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check("b1_valid", {31'd0, out_valid}, 32'd1);
          check("b1_data", {24'd0, out_data}, {24'd0, b1_exp[j]});
          check("b1_err", {31'd0, out_err}, 32'd0);
          check("b1_in_ready", {31'd0, in_ready}, 32'd1);
        end
      end
    join

    send_and_expect(8'h5A, 3'd5, 3'b110, {1'b1, 8'h5A}, "reserved_110");
    send_and_expect(8'hC7, 3'd2, 3'b101, {1'b1, 8'hC7}, "reserved_101");
    send_and_expect(8'h3E, 3'd7, 3'b111, {1'b1, 8'h3E}, "reserved_111");
    send_and_expect(8'hB1, 3'd0, 3'b100, {1'b0, 8'hB1}, "sra_by_zero");
    send_and_expect(8'hB1, 3'd0, 3'b001, {1'b0, 8'hB1}, "rol_by_zero");
    send_and_expect(8'h81, 3'd7, 3'b100, {1'b0, 8'hFF}, "sra_by_7");

    // Backpressure: only three words fit, then release.
    @(posedge clk); #1;
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1; in_data = bp_d[0]; in_amt = bp_a[0]; in_mode = bp_m[0];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 5) begin
          in_data = bp_d[idx]; in_amt = bp_a[idx]; in_mode = bp_m[idx];
        end
      end
    end
    check("bp_accepted", 32'(idx), 32'd3);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_head_word", {23'd0, out_err, out_data}, 32'h009);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_burst_valid", {31'd0, out_valid}, 32'd1);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (idx < 5) begin
        in_data = bp_d[idx]; in_amt = bp_a[idx]; in_mode = bp_m[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    check("bp_all_accepted", 32'(idx), 32'd5);
    @(negedge clk) check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset with two words in flight.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hC3; in_amt = 3'd2; in_mode = 3'd0;
    @(posedge clk); #1;
    in_data = 8'h3C; in_amt = 3'd1; in_mode = 3'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", {24'd0, out_data}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("midrst_no_stale", 32'(cnt), 32'd0);

    // 32-bit instance: two directed words, 5-stage latency.
    fork
      begin
        @(posedge clk); #1;
        v32 = 1'b1; d32 = 32'h8000_0001; a32 = 5'd31; m32 = 3'b100;
        @(posedge clk); #1;
        d32 = 32'h0000_0001; a32 = 5'd31; m32 = 3'b001;
        @(posedge clk); #1 v32 = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk) check("w32_not_early", {31'd0, ov32}, 32'd0);
        @(negedge clk);
        check("w32_sra_valid", {31'd0, ov32}, 32'd1);
        check("w32_sra_data", od32, 32'hFFFF_FFFF);
        check("w32_sra_err", {31'd0, oerr32}, 32'd0);
        @(negedge clk);
        check("w32_rol_valid", {31'd0, ov32}, 32'd1);
        check("w32_rol_data", od32, 32'h8000_0000);
      end
    join

    // Exhaustive sweep with random downstream stalls.
    @(posedge clk); #1;
    for (int m = 0; m < 5; m++) begin
      for (int a = 0; a < 8; a++) begin
        for (int d = 0; d < 256; d++) begin
          in_valid = 1'b1; in_data = 8'(d); in_amt = 3'(a); in_mode = 3'(m);
          t = 0;
          acc = 1'b0;
          while (!acc && t < 64) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            t++;
          end
          if (!acc) begin
            checks++;
            errors++;
            $display("FAIL sweep_accept_timeout: word %0d/%0d/%0d not accepted, required within 64 cycles", m, a, d);
          end
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (expq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("drain_empty", 32'(expq.size()), 32'd0);
    check("sweep_in_count", 32'(n_in), 32'd10240);
    check("sweep_out_count", 32'(n_out), 32'd10240);
    check("final_out_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
